// File: rtl/syn_i2s_dac_tx_if.sv
// -----------------------------------------------------------------------------
// syn_i2s_dac_tx_if
// PCM sample-pair handshake between a sample producer and syn_i2s_dac_tx.
//   pcm_valid  producer -> tx : sample pair offered
//   pcm_ldata  producer -> tx : left sample, two's complement
//   pcm_rdata  producer -> tx : right sample, two's complement
//   pcm_rdy    tx -> producer : holding register can accept a pair
// A pair moves in any cycle where pcm_valid and pcm_rdy are both high.
// -----------------------------------------------------------------------------
interface syn_i2s_dac_tx_if #(
   parameter int DATA_W = 16
);
   logic              pcm_valid;
   logic [DATA_W-1:0] pcm_ldata;
   logic [DATA_W-1:0] pcm_rdata;
   logic              pcm_rdy;

   modport master (output pcm_valid, pcm_ldata, pcm_rdata, input pcm_rdy);
   modport slave  (input pcm_valid, pcm_ldata, pcm_rdata, output pcm_rdy);
endinterface

// File: rtl/syn_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// syn_i2s_dac_tx
// I2S transmitter for the WM8731 DAC. Sample pairs are taken into a one-deep
// holding register and serialised MSB first with a one-BCLK delay after each
// word-clock edge, 64 BCLK per frame (32 per channel).
//
// Ports
//   acortex_clk   clock, all logic on the rising edge
//   acortex_rst   asynchronous active-high reset
//   tx_en         transmit enable; a falling tx_en finishes the current frame
//   bclk_div      BCLK half-period in clocks minus 1, taken at frame start
//   pcm           sample handshake (syn_i2s_dac_tx_if.slave)
//   AUD_BCLK      I2S bit clock
//   AUD_DACLRCK   word clock, 0 = left, 1 = right
//   AUD_DACDAT    serial data, changes on BCLK falling edges only
//   underrun      one-cycle pulse when a frame starts with no sample held
//   underrun_cnt  saturating count of underrun pulses
//                 (only with SYN_I2S_DAC_TX_UNDERRUN_CNT_EN defined)
// -----------------------------------------------------------------------------
module syn_i2s_dac_tx #(
   parameter int DATA_W = 16,
   parameter int DIV_W  = 8
) (
   input  logic               acortex_clk,
   input  logic               acortex_rst,
   input  logic               tx_en,
   input  logic [DIV_W-1:0]   bclk_div,
   syn_i2s_dac_tx_if.slave    pcm,
   output logic               AUD_BCLK,
   output logic               AUD_DACLRCK,
   output logic               AUD_DACDAT,
   output logic               underrun
`ifdef SYN_I2S_DAC_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]        underrun_cnt
`endif
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam int         SH_W    = 2 * DATA_W;
   localparam logic [4:0] DW5     = 5'(DATA_W);

   logic [0:0]        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_lat;
   logic [5:0]        bit_cnt;
   logic              hold_full;
   logic [DATA_W-1:0] hold_l;
   logic [DATA_W-1:0] hold_r;
   logic [SH_W-1:0]   shift;
   logic              bclk_q;
   logic              lrck_q;
   logic              dat_q;
   logic              ur_q;

   logic              half_end;
   logic              fall_now;
   logic              frame_end;
   logic              frame_start;
   logic              frame_stop;
   logic              xfer;
   logic [5:0]        bit_nxt;
   logic [4:0]        slot_pos;

   always_comb begin
      half_end    = (state == ST_RUN) && (div_cnt == div_lat);
      fall_now    = half_end && bclk_q;
      frame_end   = fall_now && (bit_cnt == 6'd63);
      frame_start = frame_end && tx_en;
      frame_stop  = frame_end && !tx_en;
      bit_nxt     = bit_cnt + 6'd1;
      slot_pos    = bit_nxt[4:0];
   end

   // The holding register is released in the frame-start cycle itself so a
   // producer holding pcm_valid high refills it without ever missing a frame.
   assign pcm.pcm_rdy = !hold_full || frame_start;
   assign xfer        = pcm.pcm_valid && pcm.pcm_rdy;

   always_ff @(posedge acortex_clk or posedge acortex_rst) begin
      if (acortex_rst) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         div_lat   <= '0;
         bit_cnt   <= 6'd63;
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
         shift     <= '0;
         bclk_q    <= 1'b0;
         lrck_q    <= 1'b0;
         dat_q     <= 1'b0;
         ur_q      <= 1'b0;
      end else begin
         ur_q <= 1'b0;

         // A capture in the frame-start cycle wins over the release; the old
         // content is read into the shift register below in the same cycle.
         if (xfer) begin
            hold_l    <= pcm.pcm_ldata;
            hold_r    <= pcm.pcm_rdata;
            hold_full <= 1'b1;
         end else if (frame_start) begin
            hold_full <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               div_cnt <= '0;
               div_lat <= bclk_div;
               if (tx_en) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (half_end) begin
                  div_cnt <= '0;
                  bclk_q  <= ~bclk_q;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end

               if (frame_stop) begin
                  // Last falling edge of bit 63 with tx_en low: park idle.
                  state  <= ST_IDLE;
                  lrck_q <= 1'b0;
                  dat_q  <= 1'b0;
               end else if (fall_now) begin
                  bit_cnt <= bit_nxt;
                  lrck_q  <= bit_nxt[5];
                  if (frame_start) begin
                     div_lat <= bclk_div;
                     shift   <= hold_full ? {hold_l, hold_r} : '0;
                     ur_q    <= !hold_full;
                     dat_q   <= 1'b0;
                  end else if ((slot_pos != 5'd0) && (slot_pos <= DW5)) begin
                     // Left word shifts out first; the right word is then at
                     // the top, ready for the right slot.
                     dat_q <= shift[SH_W-1];
                     shift <= {shift[SH_W-2:0], 1'b0};
                  end else begin
                     dat_q <= 1'b0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign AUD_BCLK    = bclk_q;
   assign AUD_DACLRCK = lrck_q;
   assign AUD_DACDAT  = dat_q;
   assign underrun    = ur_q;

`ifdef SYN_I2S_DAC_TX_UNDERRUN_CNT_EN
   always_ff @(posedge acortex_clk or posedge acortex_rst) begin
      if (acortex_rst) begin
         underrun_cnt <= '0;
      end else if (ur_q && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule
